// File: rtl/mem_access_unit.sv
// mem_access_unit: converts execute-stage load/store requests into
// word-aligned, byte-strobed transactions on a variable-latency data-memory
// port, and returns sign/zero-extended load data with an error cause.
// Optional feature macro: MEM_TIMEOUT_EN (abort an unacknowledged mem_req
// after TIMEOUT_CYCLES busy cycles and report cause 11).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_access,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] CAUSE_OK       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // A zero limit would abort every access before memory could answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_access;
  logic [1:0]  r_off;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_cause;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic [31:0] w_shifted;
  logic [31:0] w_ld_data;
  logic        w_timeout;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Request decode: illegal funct3 values, stores with funct3[2] set, and
  // halfword/word alignment against the incoming byte address.
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    if ((req_access[2:0] == 3'b011) || (req_access[2:0] == 3'b110) ||
        (req_access[2:0] == 3'b111) || (req_access[3] && req_access[2])) begin
      w_illegal = 1'b1;
    end
    if (req_access[1:0] == 2'b01) begin
      w_misalign = req_addr[0];
    end else if (req_access[1:0] == 2'b10) begin
      w_misalign = (req_addr[1:0] != 2'b00);
    end
  end

  // Store lane replication and byte strobes; loads never assert strobes.
  always_comb begin
    w_st_wdata = req_wdata;
    w_st_wstrb = 4'b1111;
    case (req_access[1:0])
      2'b00: begin
        w_st_wdata = {4{req_wdata[7:0]}};
        w_st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{req_wdata[15:0]}};
        w_st_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        w_st_wdata = req_wdata;
        w_st_wstrb = 4'b1111;
      end
    endcase
    if (!req_access[3]) begin
      w_st_wstrb = 4'b0000;
    end
  end

  // Load lane selection by the latched offset, then sign/zero extension.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_access[2:0])
      3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ld_data = mem_rdata;
      3'b100:  w_ld_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_ld_data = {16'd0, w_shifted[15:0]};
      default: w_ld_data = 32'd0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // An ack in the limit cycle takes precedence over the abort.
  assign w_timeout = (r_state == S_BUSY) && !mem_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Busy-cycle counter: cleared on entry to BUSY, counts unacknowledged cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUSY) && !mem_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: errors skip memory entirely, BUSY waits for ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal || w_misalign) begin
            w_next = S_RESP;
          end else begin
            w_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, memory-port registers and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_access     <= 4'd0;
      r_off        <= 2'd0;
      r_resp_rdata <= 32'd0;
      r_resp_cause <= CAUSE_OK;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_wstrb  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_access     <= req_access;
            r_off        <= req_addr[1:0];
            r_resp_rdata <= 32'd0;
            if (w_illegal) begin
              r_resp_cause <= CAUSE_ILLEGAL;
            end else if (w_misalign) begin
              r_resp_cause <= CAUSE_MISALIGN;
            end else begin
              r_resp_cause <= CAUSE_OK;
              r_mem_req    <= 1'b1;
              r_mem_we     <= req_access[3];
              r_mem_addr   <= {req_addr[31:2], 2'b00};
              r_mem_wdata  <= w_st_wdata;
              r_mem_wstrb  <= w_st_wstrb;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_cause <= CAUSE_OK;
            r_resp_rdata <= r_access[3] ? 32'd0 : w_ld_data;
          end else if (w_timeout) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_cause <= CAUSE_TIMEOUT;
            r_resp_rdata <= 32'd0;
          end
        end
        S_RESP: begin
          r_resp_rdata <= 32'd0;
          r_resp_cause <= CAUSE_OK;
        end
        default: begin
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_cause = r_resp_cause;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;

endmodule
